left_rotator_seq: RTL and testbench

Iterative 32-bit left rotator with valid/ready handshakes on both sides, for the SHA-256 datapath wherever a left rotate is needed. It is the counterpart of the combinational right rotator. For every n, left rotation by n equals right rotation by (32−n) mod 32. A 5-stage barrel decomposition (16, 8, 4, 2, 1) is applied serially, one stage per clock, so a single 32-bit shift path is reused. This trades latency for area in the message-schedule and compression control logic.

---
 rtl/left_rotator_seq.sv | 154 +++++++++++++++
 tb/tb_left_rotator_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/left_rotator_seq.sv
// Purpose : iterative 32-bit left rotator, one barrel stage (16,8,4,2,1) per clock.
// Latency : accept edge + 5 ROT cycles (fewer with LROT_EARLY_DONE_EN); result then held in DONE.
// Backpr. : valid/ready both sides; no accept while busy, result held until out_ready.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   upstream offers in_data/in_amt
//   in_ready   high only in IDLE
//   in_data    32-bit word to rotate
//   in_amt     left-rotate amount 0..31
//   out_valid  high only in DONE; qualifies out_data
//   out_ready  downstream accepts result
//   out_data   registered rotated word (0 after reset, held in IDLE)
//
// Optional feature macro: LROT_EARLY_DONE_EN
//   When defined, the operation finishes as soon as no lower amount bits remain,
//   and an amount of 0 goes straight from IDLE to DONE. Results are unchanged.

module left_rotator_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_amt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] data;
    logic [31:0] data_nxt;
    logic [4:0]  amt;
    logic [4:0]  amt_nxt;
    logic [2:0]  k;
    logic [2:0]  k_nxt;
    logic [31:0] out_q;
    logic [31:0] out_nxt;

    // Single shared rotate path: the stage index picks the rotate distance 2^k
    // and the amount bit that enables it.
    logic [31:0] stage_rot;
    logic        stage_en;
    logic [31:0] stage_res;
    logic        last_stage;

    always_comb begin
        stage_rot = data;
        stage_en  = 1'b0;
        case (k)
            3'd4: begin stage_rot = {data[15:0], data[31:16]}; stage_en = amt[4]; end
            3'd3: begin stage_rot = {data[23:0], data[31:24]}; stage_en = amt[3]; end
            3'd2: begin stage_rot = {data[27:0], data[31:28]}; stage_en = amt[2]; end
            3'd1: begin stage_rot = {data[29:0], data[31:30]}; stage_en = amt[1]; end
            3'd0: begin stage_rot = {data[30:0], data[31]};    stage_en = amt[0]; end
            default: begin
                stage_rot = data;
                stage_en  = 1'b0;
            end
        endcase
    end

    assign stage_res = stage_en ? stage_rot : data;

`ifdef LROT_EARLY_DONE_EN
    // Bits below the current stage still to be applied; when none are set the
    // remaining stages would be no-ops, so the operation can finish now.
    logic [4:0] low_mask;
    assign low_mask   = (5'd1 << k) - 5'd1;
    assign last_stage = (k == 3'd0) || ((amt & low_mask) == 5'd0);
`else
    assign last_stage = (k == 3'd0);
`endif

    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        amt_nxt   = amt;
        k_nxt     = k;
        out_nxt   = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_nxt  = in_data;
                    amt_nxt   = in_amt;
                    k_nxt     = 3'd4;
                    state_nxt = ROT;
`ifdef LROT_EARLY_DONE_EN
                    // Zero amount: the word is already the answer.
                    if (in_amt == 5'd0) begin
                        out_nxt   = in_data;
                        state_nxt = DONE;
                    end
`endif
                end
            end

            ROT: begin
                data_nxt = stage_res;
                if (last_stage) begin
                    // Capture the final stage output directly so out_data is
                    // valid in the same cycle out_valid rises.
                    out_nxt   = stage_res;
                    state_nxt = DONE;
                end else begin
                    k_nxt = k - 3'd1;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            data  <= 32'd0;
            amt   <= 5'd0;
            k     <= 3'd0;
            out_q <= 32'd0;
        end else begin
            state <= state_nxt;
            data  <= data_nxt;
            amt   <= amt_nxt;
            k     <= k_nxt;
            out_q <= out_nxt;
        end
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_left_rotator_seq.sv
// Purpose : self-checking bench for left_rotator_seq.
// Latency : expects 5 ROT cycles per operation (5-p with LROT_EARLY_DONE_EN).
// Backpr. : exercises held results under out_ready=0 and ignored in_valid while busy.

module tb_left_rotator_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];

    left_rotator_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: shift-or formulation of rotate-left.
    function automatic logic [31:0] rol_model(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference: bitwise right rotator.
    function automatic logic [31:0] ror_bits(input logic [31:0] x, input int m);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[(i + m) % 32];
        return r;
    endfunction

    function automatic int exp_rot_cycles(input logic [4:0] n);
`ifdef LROT_EARLY_DONE_EN
        if (n == 5'd0) return 0;
        for (int p = 0; p < 5; p++) if (n[p]) return 5 - p;
        return 5;
`else
        return 5;
`endif
    endfunction

    // One full operation. out_ready is left as the caller set it; when hold > 0
    // the caller has lowered it and the result is checked stable for hold cycles.
    task automatic run_op(input logic [31:0] x, input logic [4:0] n,
                          input logic [31:0] expv, input int hold,
                          output logic [31:0] got);
        int cnt;
        logic [31:0] e;
        cnt = 0;
        while (!in_ready && cnt < 20) begin tick(); cnt++; end
        check_bit("ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = x;
        in_amt   = n;
        exp_q.push_back(expv);
        tick();
        // Keep offering garbage while busy: must be ignored, not queued.
        in_data = $urandom;
        in_amt  = 5'($urandom);
        cnt = 0;
        while (!out_valid && cnt < 40) begin tick(); cnt++; end
        check("latency", 32'(cnt), 32'(exp_rot_cycles(n)));
        e = exp_q.pop_front();
        check_bit("out_valid_seen", out_valid, 1'b1);
        check("out_data", out_data, e);
        check_bit("in_ready_busy", in_ready, 1'b0);
        got = out_data;
        in_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_data", out_data, e);
            check_bit("hold_valid", out_valid, 1'b1);
            check_bit("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        check_bit("post_hs_valid", out_valid, 1'b0);
        check_bit("post_hs_in_ready", in_ready, 1'b1);
    endtask

    typedef struct {
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] got;
        logic [31:0] x;
        logic        saw_valid;

        vecs[0] = '{data: 32'h80000001, amt: 5'd1,  exp: 32'h00000003};
        vecs[1] = '{data: 32'h12345678, amt: 5'd4,  exp: 32'h23456781};
        vecs[2] = '{data: 32'h12345678, amt: 5'd16, exp: 32'h56781234};
        vecs[3] = '{data: 32'h12345678, amt: 5'd0,  exp: 32'h12345678};
        vecs[4] = '{data: 32'h00000001, amt: 5'd31, exp: 32'h80000000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_amt    = 5'd0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_in_ready", in_ready, 1'b1);
        check("reset_out_data", out_data, 32'd0);

        // Table vectors, out_ready already high before out_valid.
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].data, vecs[i].amt, vecs[i].exp, 0, got);
        end

        // out_data retained in IDLE.
        tick();
        check("idle_retain", out_data, 32'h80000000);

        // Backpressure: hold out_ready low 10 cycles, then a one-cycle pulse.
        out_ready = 1'b0;
        run_op(32'hDEADBEEF, 5'd12, rol_model(32'hDEADBEEF, 12), 10, got);
        out_ready = 1'b0;
        tick();
        check_bit("pulse_no_reaccept", out_valid, 1'b0);
        out_ready = 1'b1;

        // Reset during ROT, two cycles after accept.
        in_valid = 1'b1;
        in_data  = 32'h0F0F1234;
        in_amt   = 5'd7;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_bit("midrot_rst_out_valid", out_valid, 1'b0);
        check_bit("midrot_rst_in_ready", in_ready, 1'b1);
        check("midrot_rst_out_data", out_data, 32'd0);
        saw_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        check_bit("midrot_discarded", saw_valid, 1'b0);
        run_op(32'hA5A5A5A5, 5'd8, 32'hA5A5A5A5, 0, got);

        // Reset while in DONE with out_ready low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h00000F00;
        in_amt    = 5'd3;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        check_bit("done_before_rst", out_valid, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_bit("done_rst_out_valid", out_valid, 1'b0);
        check("done_rst_out_data", out_data, 32'd0);
        out_ready = 1'b1;

        // Every amount on random words, against two independent references.
        for (int n = 0; n < 32; n++) begin
            x = $urandom;
            run_op(x, 5'(n), rol_model(x, n), 0, got);
            check("vs_ror", got, ror_bits(x, (32 - n) % 32));
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
